// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core request bundle and RAM port of the shared data-memory arbiter
interface dmem_arbiter_if #(
  parameter int NCORES = 4,
  parameter int DW     = 8,
  parameter int AW     = 8
);
  logic [NCORES-1:0]    req_rd;
  logic [NCORES-1:0]    req_wr;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    acq;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_din;
  logic                 mem_wen;
  logic [DW-1:0]        mem_dout;

  modport slave (
    input  req_rd, req_wr, addr, wdata, mem_dout,
    output acq, rdata, mem_addr, mem_din, mem_wen
  );

  modport master (
    output req_rd, req_wr, addr, wdata, mem_dout,
    input  acq, rdata, mem_addr, mem_din, mem_wen
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin shared data-memory port; DMEM_ARB_FIXED_PRIO_EN selects fixed priority
module dmem_arbiter #(
  parameter int NCORES = 4,
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_arbiter_if.slave bus
);
  localparam int IDW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCORES-1:0] mask_q, mask_d;
  logic [NCORES-1:0] acq_q, acq_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_din_q, mem_din_d;
  logic              mem_wen_q, mem_wen_d;

  logic [AW-1:0]     addr_arr  [NCORES];
  logic [DW-1:0]     wdata_arr [NCORES];
  logic [NCORES-1:0] eligible;
  logic              found;
  logic [IDW-1:0]    winner;
  logic [IDW:0]      idx;

  for (genvar g = 0; g < NCORES; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr[g*AW +: AW];
    assign wdata_arr[g] = bus.wdata[g*DW +: DW];
  end

  // The mask hides the just-served core for one IDLE cycle while its request drops.
  assign eligible = (bus.req_rd | bus.req_wr) & ~mask_q;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NCORES; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      idx = (IDW+1)'(i);
`else
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NCORES)) idx = idx - (IDW+1)'(NCORES);
`endif
      if (!found && eligible[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    acq_d      = '0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wen_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        mask_d = '0;
        if (found) begin
          id_d       = winner;
          wr_d       = bus.req_wr[winner];
          mem_addr_d = addr_arr[winner];
          mem_din_d  = wdata_arr[winner];
          mem_wen_d  = bus.req_wr[winner];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          acq_d[id_q] = 1'b1;
          state_d     = ACK;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d     = bus.mem_dout;
          acq_d[id_q] = 1'b1;
          state_d     = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
        if (id_q == IDW'(NCORES - 1)) rr_ptr_d = '0;
        else                          rr_ptr_d = id_q + 1'b1;
`endif
        mask_d         = '0;
        mask_d[id_q]   = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      mask_q     <= '0;
      acq_q      <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      acq_q      <= acq_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wen_q  <= mem_wen_d;
    end
  end

  assign bus.acq      = acq_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_wen  = mem_wen_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a two-cycle-latency RAM model
module tb_dmem_arbiter;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NCORES(NC), .DW(DW), .AW(AW)) bus ();

  dmem_arbiter #(.NCORES(NC), .DW(DW), .AW(AW), .RD_LAT(RL)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_din;
    rd_s1        <= ram[bus.mem_addr];
    bus.mem_dout <= rd_s1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int grant_ids [8];

  task automatic clear_reqs();
    bus.req_rd = '0;
    bus.req_wr = '0;
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_rd[c]           = rd;
    bus.req_wr[c]           = wr;
    bus.addr[c*AW +: AW]    = a;
    bus.wdata[c*DW +: DW]   = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_acq(output int cyc, output logic [NC-1:0] a);
    cyc = -1;
    a   = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.acq != '0) begin
        cyc = k;
        a   = bus.acq;
        return;
      end
    end
  endtask

  task automatic collect(input int n, output int got, output int multi, output int repeats);
    int last;
    last = -1; got = 0; multi = 0; repeats = 0;
    for (int k = 0; k < 60 && got < n; k++) begin
      @(negedge clk);
      if ($countones(bus.acq) > 1) multi++;
      else if (bus.acq != '0) begin
        for (int b = 0; b < NC; b++) begin
          if (bus.acq[b]) begin
            if (b == last) repeats++;
            grant_ids[got] = b;
            last = b;
          end
        end
        got++;
      end
    end
  endtask

  task automatic test_reset();
    clear_reqs();
    bus.addr  = '0;
    bus.wdata = '0;
    @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL reset_acq: got %b expected 0000", bus.acq); end
    n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
    n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 00", bus.mem_addr); end
    n_checks++; if (bus.mem_din !== 8'h00) begin n_fail++; $display("FAIL reset_mem_din: got %h expected 00", bus.mem_din); end
    n_checks++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wen: got %b expected 0", bus.mem_wen); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    set_req(1, 1'b0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    n_checks++; if (bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL wr_wen_c1: got %b expected 1", bus.mem_wen); end
    n_checks++; if (bus.mem_addr !== 8'h10) begin n_fail++; $display("FAIL wr_addr_c1: got %h expected 10", bus.mem_addr); end
    n_checks++; if (bus.mem_din !== 8'hA5) begin n_fail++; $display("FAIL wr_din_c1: got %h expected a5", bus.mem_din); end
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL wr_acq_c1: got %b expected 0000", bus.acq); end
    @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0010) begin n_fail++; $display("FAIL wr_acq_c2: got %b expected 0010", bus.acq); end
    n_checks++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL wr_wen_c2: got %b expected 0", bus.mem_wen); end
    @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL wr_acq_c3: got %b expected 0000", bus.acq); end
    @(negedge clk);
    n_checks++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL wr_stale_regrant: got %b expected 0", bus.mem_wen); end
    n_checks++; if (ram[8'h10] !== 8'hA5) begin n_fail++; $display("FAIL wr_ram: got %h expected a5", ram[8'h10]); end
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_read();
    int cyc;
    logic [NC-1:0] a;
    set_req(2, 1'b1, 1'b0, 8'h10, 8'h00);
    wait_acq(cyc, a);
    n_checks++; if (cyc != 2 + RL) begin n_fail++; $display("FAIL rd_latency: got %0d expected %0d", cyc, 2 + RL); end
    n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL rd_acq: got %b expected 0100", a); end
    n_checks++; if (bus.rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h expected a5", bus.rdata); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    set_req(0, 1'b0, 1'b1, 8'h20, 8'h3C);
    wait_acq(cyc, a);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL rd_then_wr_latency: got %0d expected 2", cyc); end
    n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL rd_then_wr_acq: got %b expected 0001", a); end
    n_checks++; if (bus.rdata !== 8'hA5) begin n_fail++; $display("FAIL rdata_hold: got %h expected a5", bus.rdata); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [NC-1:0] a;
    set_req(2, 1'b1, 1'b0, 8'h10, 8'h00);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL rstmid_acq: got %b expected 0000", bus.acq); end
    n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 00", bus.rdata); end
    n_checks++; if (bus.mem_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_mem_addr: got %h expected 00", bus.mem_addr); end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL rstmid_no_acq: got %b expected 0000", bus.acq); end
    clear_reqs();
    rst = 1'b0;
    @(negedge clk);
    set_req(3, 1'b0, 1'b1, 8'h40, 8'h5A);
    @(negedge clk);
    n_checks++; if (bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL rstwr_wen_before: got %b expected 1", bus.mem_wen); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL rstwr_wen_drop: got %b expected 0", bus.mem_wen); end
    @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0000) begin n_fail++; $display("FAIL rstwr_no_acq: got %b expected 0000", bus.acq); end
    clear_reqs();
    rst = 1'b0;
    @(negedge clk);
    set_req(3, 1'b0, 1'b1, 8'h41, 8'h5B);
    wait_acq(cyc, a);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 2", cyc); end
    n_checks++; if (a !== 4'b1000) begin n_fail++; $display("FAIL post_rst_acq: got %b expected 1000", a); end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int got, multi, repeats;
    int exp_ids [5];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 1, 0, 1, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    do_reset();
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 1'b1, 8'h50 + 8'(c), 8'h60 + 8'(c));
    collect(5, got, multi, repeats);
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", got); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i < got && grant_ids[i] != exp_ids[i]) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, grant_ids[i], exp_ids[i]);
      end
    end
    n_checks++; if (multi != 0) begin n_fail++; $display("FAIL rr_multi_hot: got %0d expected 0", multi); end
    n_checks++; if (repeats != 0) begin n_fail++; $display("FAIL rr_repeat: got %0d expected 0", repeats); end
    clear_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    int got, multi, repeats, cyc, exp_first;
    logic [NC-1:0] a;
    do_reset();
    set_req(0, 1'b0, 1'b1, 8'h70, 8'h11);
    set_req(3, 1'b0, 1'b1, 8'h73, 8'h33);
    collect(3, got, multi, repeats);
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL prio_grant_count: got %0d expected 3", got); end
    n_checks++; if (got == 3 && (grant_ids[0] != 0 || grant_ids[1] != 3 || grant_ids[2] != 0)) begin
      n_fail++; $display("FAIL prio_order: got %0d %0d %0d expected 0 3 0", grant_ids[0], grant_ids[1], grant_ids[2]);
    end
    do_reset();
    set_req(1, 1'b0, 1'b1, 8'h71, 8'h22);
    wait_acq(cyc, a);
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_first = 0;
`else
    exp_first = 3;
`endif
    set_req(0, 1'b0, 1'b1, 8'h70, 8'h11);
    set_req(3, 1'b0, 1'b1, 8'h73, 8'h33);
    collect(1, got, multi, repeats);
    n_checks++; if (got != 1 || grant_ids[0] != exp_first) begin
      n_fail++; $display("FAIL arb_after_core1: got %0d expected %0d", grant_ids[0], exp_first);
    end
    do_reset();
    set_req(2, 1'b1, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    n_checks++; if (bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL rdwr_wen: got %b expected 1", bus.mem_wen); end
    n_checks++; if (bus.mem_din !== 8'h77) begin n_fail++; $display("FAIL rdwr_din: got %h expected 77", bus.mem_din); end
    @(negedge clk);
    n_checks++; if (bus.acq !== 4'b0100) begin n_fail++; $display("FAIL rdwr_acq_c2: got %b expected 0100", bus.acq); end
    n_checks++; if (ram[8'h30] !== 8'h77) begin n_fail++; $display("FAIL rdwr_ram: got %h expected 77", ram[8'h30]); end
    clear_reqs();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_round_robin();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
